multicycle_controller: RTL and testbench

- Moore-style FSM that sequences a multi-cycle RV32I datapath: fetch, decode, execute, memory access and writeback.
- Drives the datapath mux selects, ALU op class, register/PC/IR enables and the immediate-format select (imm_src) of the existing immediate extender.
- Memory accesses use a req/ready handshake, so each access stalls until the memory acknowledges.
- Unsupported opcodes enter a sticky trap state.

---
 rtl/rv32_ctrl_pkg.sv | 84 ++++++++
 rtl/branch_cond.sv | 28 ++
 rtl/multicycle_controller.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, opcodes, mux selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Every datapath control the FSM drives, bundled so reset gating is one mux.
  typedef struct packed {
    logic [2:0] imm_src;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_req;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       instr_retired;
    logic       illegal;
  } ctrl_t;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm_of = IMM_I;
      OP_STORE:                 imm_of = IMM_S;
      OP_BRANCH:                imm_of = IMM_B;
      OP_JAL:                   imm_of = IMM_J;
      OP_LUI, OP_AUIPC:         imm_of = IMM_U;
      default:                  imm_of = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch outcome from ALU compare flags and funct3.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3/zero/lt/ltu in; taken = branch condition holds, bad_funct3 = 010/011.
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       bad_funct3
);

  always_comb begin
    taken      = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multi-cycle RV32I datapath (fetch/decode/execute/mem/writeback).
// Latency: 3-5 cycles per instruction with zero-wait memory; one state per cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold mem_req until mem_ready, stalling the FSM.
// Ports: op/funct3/funct7b5 from IR, zero/lt/ltu ALU flags, mem_ready handshake in;
//        mux selects, enables, mem_req/mem_write, instr_retired, illegal, state_o out.
module multicycle_controller
  import rv32_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic [2:0] imm_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_retired,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  ctrl_t  ctrl, ctrl_out;
  logic   taken, bad_funct3;

  // funct7b5 is consumed by the downstream ALU decoder, not by the sequencer.
  logic unused_funct7b5;
  assign unused_funct7b5 = funct7b5;

  branch_cond u_branch_cond (
    .funct3     (funct3),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .taken      (taken),
    .bad_funct3 (bad_funct3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    if (state_q != S_FETCH) ctrl.imm_src = imm_of(op);
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut <= oldPC + imm: the target for branch, JAL and AUIPC.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write     = 1'b1;
        ctrl.result_src    = RES_MEM;
        ctrl.instr_retired = 1'b1;
        state_d            = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
        if (mem_ready) begin
          ctrl.instr_retired = 1'b1;
          state_d            = S_FETCH;
        end
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = S_ALUWB;
      end
      S_LUI: begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write     = 1'b1;
        ctrl.result_src    = RES_ALUOUT;
        ctrl.instr_retired = 1'b1;
        state_d            = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        if (bad_funct3) begin
          state_d = S_TRAP;
        end else begin
          ctrl.pc_write      = taken;
          ctrl.instr_retired = 1'b1;
          state_d            = S_FETCH;
        end
      end
      S_JALR: begin
        // Overwrites ALUOut with rs1+imm, then shares the JAL state.
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = S_JAL;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms oldPC+4 as link value.
        ctrl.pc_write   = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        state_d         = S_ALUWB;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Outputs are held at zero while reset is asserted, so an in-flight
  // memory request is withdrawn the moment rst_n falls.
  assign ctrl_out      = rst_n ? ctrl : '0;
  assign imm_src       = ctrl_out.imm_src;
  assign pc_write      = ctrl_out.pc_write;
  assign ir_write      = ctrl_out.ir_write;
  assign adr_src       = ctrl_out.adr_src;
  assign mem_req       = ctrl_out.mem_req;
  assign mem_write     = ctrl_out.mem_write;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign result_src    = ctrl_out.result_src;
  assign instr_retired = ctrl_out.instr_retired;
  assign illegal       = ctrl_out.illegal;
  assign state_o       = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instruction classes cycle by cycle.
// Latency: n/a.
// Backpressure: mem_ready driven directly by the stimulus.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;
  logic [2:0] imm_src;
  logic       pc_write, ir_write, adr_src, mem_req, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       instr_retired, illegal;
  logic [3:0] state_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.RESET_STATE(4'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .lt            (lt),
    .ltu           (ltu),
    .mem_ready     (mem_ready),
    .imm_src       (imm_src),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .adr_src       (adr_src),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .result_src    (result_src),
    .instr_retired (instr_retired),
    .illegal       (illegal),
    .state_o       (state_o)
  );

  // Field order: state, imm, pc_write, ir_write, adr_src, mem_req, mem_write,
  // reg_write, alu_src_a, alu_src_b, alu_op, result_src, instr_retired, illegal.
  function automatic logic [22:0] mk(int st, int im, int pw, int iw, int ad, int rq,
                                     int mw, int rw, int a, int b, int ao, int rs,
                                     int rt, int il);
    return {st[3:0], im[2:0], pw[0], iw[0], ad[0], rq[0], mw[0], rw[0],
            a[1:0], b[1:0], ao[1:0], rs[1:0], rt[0], il[0]};
  endfunction

  function automatic logic [22:0] outs();
    return {state_o, imm_src, pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
            alu_src_a, alu_src_b, alu_op, result_src, instr_retired, illegal};
  endfunction

  function automatic logic [22:0] e_fetch(int rdy);
    return mk(0, 0, rdy, rdy, 0, 1, 0, 0, 0, 2, 0, 2, 0, 0);
  endfunction
  function automatic logic [22:0] e_decode(int im);
    return mk(1, im, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
  endfunction
  function automatic logic [22:0] e_memadr(int im);
    return mk(2, im, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
  endfunction
  function automatic logic [22:0] e_memread(int im);
    return mk(3, im, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [22:0] e_aluwb(int im);
    return mk(8, im, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
  endfunction
  function automatic logic [22:0] e_trap();
    return mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic chk(input string tag, input logic [22:0] o, input logic [22:0] e);
    total_cnt++;
    assert (o === e) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check combinational outputs mid-cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [22:0] e);
    @(negedge clk);
    chk(tag, outs(), e);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;

    // Reset: everything forced to zero even though FETCH + mem_ready would assert enables.
    @(negedge clk);
    chk("reset_outputs", outs(), 23'd0);
    tick();

    // Fetch with three wait cycles.
    rst_n = 1'b1; mem_ready = 1'b0;
    cyc("fetch_wait1", e_fetch(0));
    cyc("fetch_wait2", e_fetch(0));
    cyc("fetch_wait3", e_fetch(0));
    mem_ready = 1'b1;
    cyc("fetch_ready", e_fetch(1));

    // add: mem_ready high in DECODE/EXECR must be ignored.
    cyc("add_decode", e_decode(0));
    cyc("add_execr",  mk(6, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
    cyc("add_aluwb",  e_aluwb(0));

    // lw with two wait cycles in MEMREAD.
    op = 7'b0000011; funct3 = 3'b010;
    cyc("lw_fetch",  e_fetch(1));
    cyc("lw_decode", e_decode(0));
    cyc("lw_memadr", e_memadr(0));
    mem_ready = 1'b0;
    cyc("lw_memread_w1", e_memread(0));
    cyc("lw_memread_w2", e_memread(0));
    mem_ready = 1'b1;
    cyc("lw_memread_rdy", e_memread(0));
    cyc("lw_memwb", mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));

    // beq taken, bne not taken, bgeu taken.
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    cyc("beq_fetch",  e_fetch(1));
    cyc("beq_decode", e_decode(2));
    cyc("beq_branch", mk(9, 2, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0));
    funct3 = 3'b001;
    cyc("bne_fetch",  e_fetch(1));
    cyc("bne_decode", e_decode(2));
    cyc("bne_branch", mk(9, 2, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0));
    funct3 = 3'b111; ltu = 1'b0; lt = 1'b1;
    cyc("bgeu_fetch",  e_fetch(1));
    cyc("bgeu_decode", e_decode(2));
    cyc("bgeu_branch", mk(9, 2, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0));
    zero = 1'b0; lt = 1'b0;

    // jal.
    op = 7'b1101111;
    cyc("jal_fetch",  e_fetch(1));
    cyc("jal_decode", e_decode(3));
    cyc("jal_jal",    mk(10, 3, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    cyc("jal_aluwb",  e_aluwb(3));

    // jalr passes through JAL.
    op = 7'b1100111;
    cyc("jalr_fetch",  e_fetch(1));
    cyc("jalr_decode", e_decode(0));
    cyc("jalr_jalr",   mk(11, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
    cyc("jalr_jal",    mk(10, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    cyc("jalr_aluwb",  e_aluwb(0));

    // sw with zero-wait memory.
    op = 7'b0100011;
    cyc("sw_fetch",    e_fetch(1));
    cyc("sw_decode",   e_decode(1));
    cyc("sw_memadr",   e_memadr(1));
    cyc("sw_memwrite", mk(5, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0));

    // Reset asserted while a load waits on memory.
    op = 7'b0000011;
    cyc("lwr_fetch",  e_fetch(1));
    cyc("lwr_decode", e_decode(0));
    cyc("lwr_memadr", e_memadr(0));
    mem_ready = 1'b0;
    cyc("lwr_memread_w1", e_memread(0));
    @(negedge clk);
    chk("lwr_memread_w2", outs(), e_memread(0));
    rst_n = 1'b0;
    #1;
    chk("lwr_reset_mid", outs(), 23'd0);
    tick();
    rst_n = 1'b1; mem_ready = 1'b1; op = 7'b0000000;
    cyc("post_reset_fetch", e_fetch(1));

    // Unsupported opcode: sticky trap, memory handshake ignored.
    cyc("bad_op_decode", e_decode(0));
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      cyc($sformatf("trap_hold%0d", i), e_trap());
    end

    // Asynchronous reset clears the trap.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("trap_reset", outs(), 23'd0);
    tick();
    rst_n = 1'b1; mem_ready = 1'b1;

    // Branch with reserved funct3 traps without pc_write or retire.
    op = 7'b1100011; funct3 = 3'b010; zero = 1'b1;
    cyc("bad_br_fetch",  e_fetch(1));
    cyc("bad_br_decode", e_decode(2));
    cyc("bad_br_branch", mk(9, 2, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0));
    op = 7'b0000000;
    cyc("bad_br_trap", e_trap());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
